// File: rtl/text_rx_sink.sv
// Receive-side text sink: buffers decompressed characters in a FIFO and frames
// messages on EOM_CHAR, reporting length, checksum and non-printable count.
module text_rx_sink #(
  parameter int          DEPTH    = 16,
  parameter logic [7:0]  EOM_CHAR = 8'h0A
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               data_in,
  input  logic                     data_valid,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     msg_done,
  output logic [15:0]              msg_len,
  output logic [7:0]               msg_checksum,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    err_q, err_d;
  logic          msg_done_q, msg_done_d;
  logic [15:0]   msg_len_q, msg_len_d;
  logic [7:0]    msg_cs_q, msg_cs_d;
  logic [7:0]    msg_err_q, msg_err_d;
  logic          is_eom, nonprint;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    pop        = rd_en && !empty_q;
    push       = data_valid && (!full_q || pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    empty_d    = (level_d == '0);
    full_d     = (level_d == LW'(DEPTH));
    ovf_d      = ovf_q || (data_valid && !push);
    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Framing sees every valid character, including ones the FIFO had to drop.
  always_comb begin
    is_eom     = (data_in == EOM_CHAR);
    nonprint   = ((data_in < 8'h20) || (data_in > 8'h7E)) && !is_eom;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    err_d      = err_q;
    msg_done_d = 1'b0;
    msg_len_d  = msg_len_q;
    msg_cs_d   = msg_cs_q;
    msg_err_d  = msg_err_q;
    case (state_q)
      RECV: begin
        if (data_valid) begin
          if (is_eom) begin
            state_d    = DONE;
            msg_done_d = 1'b1;
            msg_len_d  = cnt_q;
            msg_cs_d   = sum_q;
            msg_err_d  = err_q;
          end else begin
            cnt_d = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
            sum_d = sum_q + data_in;
            err_d = (nonprint && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
          end
        end
      end
      default: begin
        // DONE behaves like IDLE for incoming data so back-to-back messages chain.
        state_d = IDLE;
        if (data_valid) begin
          if (is_eom) begin
            msg_done_d = 1'b1;
            msg_len_d  = '0;
            msg_cs_d   = '0;
            msg_err_d  = '0;
          end else begin
            state_d = RECV;
            cnt_d   = 16'd1;
            sum_d   = data_in;
            err_d   = {7'b0, nonprint};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      err_q      <= '0;
      msg_done_q <= 1'b0;
      msg_len_q  <= '0;
      msg_cs_q   <= '0;
      msg_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      msg_done_q <= msg_done_d;
      msg_len_q  <= msg_len_d;
      msg_cs_q   <= msg_cs_d;
      msg_err_q  <= msg_err_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;
  assign msg_done     = msg_done_q;
  assign msg_len      = msg_len_q;
  assign msg_checksum = msg_cs_q;
  assign err_count    = msg_err_q;

endmodule

// File: tb/tb_text_rx_sink.sv
// Directed bench for text_rx_sink: a vector table for the message/FIFO basics
// plus hand sequences for overflow, full push+pop and mid-message reset.
module tb_text_rx_sink;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       msg_done;
  logic [15:0] msg_len;
  logic [7:0] msg_checksum;
  logic [7:0] err_count;

  int tests_run = 0;
  int tests_failed = 0;

  text_rx_sink #(.DEPTH(DEPTH), .EOM_CHAR(8'h0A)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .overflow(overflow), .msg_done(msg_done), .msg_len(msg_len),
    .msg_checksum(msg_checksum), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [7:0]  din;
    logic        rd;
    logic        rv;
    logic [7:0]  rdat;
    logic [4:0]  lvl;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        done;
    logic [15:0] len;
    logic [7:0]  cs;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle at the falling edge, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic dv, input logic [7:0] din, input logic rd);
    @(negedge clk);
    data_valid = dv;
    data_in    = din;
    rd_en      = rd;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    rd_en      = 1'b0;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    checkOutput({tag, ".rd_valid"},   16'(rd_valid),     16'(v.rv));
    checkOutput({tag, ".rd_data"},    16'(rd_data),      16'(v.rdat));
    checkOutput({tag, ".level"},      16'(fifo_level),   16'(v.lvl));
    checkOutput({tag, ".empty"},      16'(fifo_empty),   16'(v.empty));
    checkOutput({tag, ".full"},       16'(fifo_full),    16'(v.full));
    checkOutput({tag, ".overflow"},   16'(overflow),     16'(v.ovf));
    checkOutput({tag, ".msg_done"},   16'(msg_done),     16'(v.done));
    checkOutput({tag, ".msg_len"},    msg_len,           v.len);
    checkOutput({tag, ".checksum"},   16'(msg_checksum), 16'(v.cs));
    checkOutput({tag, ".err_count"},  16'(err_count),    16'(v.err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    data_valid = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // dv din rd | rv rdat lvl empty full ovf done len cs err
    vecs[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 8'h49, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 8'h91, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h49, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h0A, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[8]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h0A, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[9]  = '{1'b1, 8'h07, 1'b0, 1'b0, 8'h0A, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[10] = '{1'b1, 8'h7F, 1'b0, 1'b0, 8'h0A, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[11] = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h0A, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 8'h91, 8'h00};
    vecs[12] = '{1'b1, 8'h0A, 1'b0, 1'b0, 8'h0A, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 8'h09, 8'h02};
    vecs[13] = '{1'b1, 8'h0A, 1'b0, 1'b0, 8'h0A, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'h00, 8'h00};
    vecs[14] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h0A, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00};
    vecs[15] = '{1'b1, 8'h0A, 1'b0, 1'b0, 8'h0A, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 8'h41, 8'h00};
    vecs[16] = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h41, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 8'h41, 8'h00};
    vecs[17] = '{1'b1, 8'h0A, 1'b0, 1'b0, 8'h41, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 8'h42, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset.empty",    16'(fifo_empty),   16'd1);
    checkOutput("reset.level",    16'(fifo_level),   16'd0);
    checkOutput("reset.rd_valid", 16'(rd_valid),     16'd0);
    checkOutput("reset.msg_done", 16'(msg_done),     16'd0);
    checkOutput("reset.msg_len",  msg_len,           16'd0);
    checkOutput("reset.overflow", 16'(overflow),     16'd0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].dv, vecs[i].din, vecs[i].rd);
      check_row($sformatf("row%0d", i), vecs[i]);
    end

    // Fill past capacity: the last two writes are dropped
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b1, 8'(8'h61 + i), 1'b0);
      checkOutput($sformatf("fill%0d.level", i), 16'(fifo_level), (i + 1 >= DEPTH) ? 16'(DEPTH) : 16'(i + 1));
      checkOutput($sformatf("fill%0d.full", i), 16'(fifo_full), (i + 1 >= DEPTH) ? 16'd1 : 16'd0);
      checkOutput($sformatf("fill%0d.overflow", i), 16'(overflow), (i >= DEPTH) ? 16'd1 : 16'd0);
    end

    // Push and pop together while full
    applyStimulus(1'b1, 8'h5F, 1'b1);
    checkOutput("fullpp.level",    16'(fifo_level), 16'(DEPTH));
    checkOutput("fullpp.full",     16'(fifo_full),  16'd1);
    checkOutput("fullpp.overflow", 16'(overflow),   16'd1);
    checkOutput("fullpp.rd_valid", 16'(rd_valid),   16'd1);
    checkOutput("fullpp.rd_data",  16'(rd_data),    16'h61);
    for (int k = 1; k < DEPTH; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain%0d.rd_valid", k), 16'(rd_valid), 16'd1);
      checkOutput($sformatf("drain%0d.rd_data", k),  16'(rd_data),  16'(8'(8'h61 + k)));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drainlast.rd_data",  16'(rd_data),    16'h5F);
    checkOutput("drainlast.empty",    16'(fifo_empty), 16'd1);
    checkOutput("drainlast.level",    16'(fifo_level), 16'd0);
    checkOutput("drainlast.overflow", 16'(overflow),   16'd1);

    // Reset abandons a half-received message
    do_reset();
    applyStimulus(1'b1, 8'h41, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("midrst.pre_level", 16'(fifo_level), 16'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst.level",    16'(fifo_level), 16'd0);
    checkOutput("midrst.empty",    16'(fifo_empty), 16'd1);
    checkOutput("midrst.msg_done", 16'(msg_done),   16'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0);
    checkOutput("midrst.z_done",   16'(msg_done),     16'd0);
    applyStimulus(1'b1, 8'h0A, 1'b0);
    checkOutput("midrst.eom_done", 16'(msg_done),     16'd1);
    checkOutput("midrst.msg_len",  msg_len,           16'd1);
    checkOutput("midrst.checksum", 16'(msg_checksum), 16'h5A);
    checkOutput("midrst.err",      16'(err_count),    16'd0);
    checkOutput("midrst.level",    16'(fifo_level),   16'd2);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst.done_pulse", 16'(msg_done),   16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
